// File: rtl/mux4.sv
// mux4: registered 4:1 multiplexer with capture enable.
// z loads the input chosen by sel one clock after sampling, and z_sel records
// which sel value produced the current z. A synchronous, active-high reset
// clears both and overrides en.
module mux4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] z,
  output logic [1:0]       z_sel
);

  logic [WIDTH-1:0] mux_d;

  // Bitwise 4:1 selection; non-selected inputs never reach mux_d.
  always_comb begin
    mux_d = '0;
    unique case (sel)
      2'b00:   mux_d = d0;
      2'b01:   mux_d = d1;
      2'b10:   mux_d = d2;
      2'b11:   mux_d = d3;
      default: mux_d = '0;
    endcase
  end

  // Output register: reset has priority, otherwise load on en, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      z     <= '0;
      z_sel <= 2'b00;
    end else if (en) begin
      z     <= mux_d;
      z_sel <= sel;
    end
  end

endmodule

// File: tb/tb_mux4.sv
// tb_mux4: scoreboard bench for mux4. The driver applies one vector per clock
// and queues the expected z/z_sel for after that edge; a monitor on the
// falling edge pops each entry and compares it against the DUT.
module tb_mux4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d0, d1, d2, d3;
  logic [1:0]   sel;
  logic         en;
  logic [W-1:0] z;
  logic [1:0]   z_sel;

  typedef struct {
    logic [W-1:0] ez;
    logic [1:0]   es;
    int           id;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int vec   = 0;

  // Reference state for the random section; follows every queued expectation.
  logic [W-1:0] mz = '0;
  logic [1:0]   ms = 2'b00;

  mux4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .sel   (sel),
    .en    (en),
    .z     (z),
    .z_sel (z_sel)
  );

  always #5 clk = ~clk;

  // Monitor: one registered result is presented per clock; check it mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (z !== e.ez || z_sel !== e.es) begin
        bad++;
        $display("FAIL vec%0d: z=%h z_sel=%b, expected z=%h z_sel=%b",
                 e.id, z, z_sel, e.ez, e.es);
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic [1:0] s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic [W-1:0] ez, input logic [1:0] es);
    exp_t x;
    rst = r; en = e; sel = s; d0 = a; d1 = b; d2 = c; d3 = d;
    @(posedge clk);
    x.ez = ez; x.es = es; x.id = vec;
    exp_q.push_back(x);
    mz = ez; ms = es;
    vec++;
    #1;
  endtask

  initial begin
    logic [W-1:0] oh [4];
    logic [W-1:0] ra, rb, rc, rd, rz;
    logic [1:0]   rs, rzs;
    logic         rr, re;

    rst = 1'b0; en = 1'b0; sel = 2'b00;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    #1;

    // Reset with everything else active, then first load with no dead cycle.
    drive(1, 1, 2'b11, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 2'b00);
    drive(0, 1, 2'b11, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 2'b11);

    // Select sweep.
    drive(0, 1, 2'b00, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 2'b00);
    drive(0, 1, 2'b10, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 2'b10);
    drive(0, 1, 2'b00, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 2'b00);

    // One-hot exhaustive: only dk is 1; z is 1 only when sel == k.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) oh[i] = (i == k) ? 4'h1 : 4'h0;
      for (int s = 0; s < 4; s++)
        drive(0, 1, 2'(s), oh[0], oh[1], oh[2], oh[3],
              (s == k) ? 4'h1 : 4'h0, 2'(s));
    end

    // Hold: en=0 keeps z/z_sel while sel and data move.
    drive(0, 1, 2'b00, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 2'b00);
    repeat (3) drive(0, 0, 2'b01, 4'h0, 4'h6, 4'h0, 4'h0, 4'h1, 2'b00);
    drive(0, 1, 2'b01, 4'h0, 4'h6, 4'h0, 4'h0, 4'h6, 2'b01);

    // Reset beats enable; release loads on the next edge.
    drive(1, 1, 2'b00, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00);
    drive(0, 1, 2'b00, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 2'b00);

    // Bitwise selection on multi-bit data, sel changing every cycle.
    drive(0, 1, 2'b10, 4'hF, 4'h0, 4'hA, 4'h5, 4'hA, 2'b10);
    drive(0, 1, 2'b11, 4'hF, 4'h0, 4'hA, 4'h5, 4'h5, 2'b11);
    drive(0, 1, 2'b01, 4'hF, 4'h0, 4'hA, 4'h5, 4'h0, 2'b01);
    drive(0, 1, 2'b00, 4'hF, 4'h0, 4'hA, 4'h5, 4'hF, 2'b00);

    // Reset with en=0 still clears.
    drive(1, 0, 2'b11, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 2'b00);

    // Unknown values on non-selected inputs do not disturb z.
    drive(0, 1, 2'b01, 4'hx, 4'h3, 4'hx, 4'hx, 4'h3, 2'b01);
    drive(0, 1, 2'b10, 4'h9, 4'hx, 4'hC, 4'hx, 4'hC, 2'b10);

    // Random traffic against a one-cycle-delayed reference.
    for (int n = 0; n < 1000; n++) begin
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom); rd = 4'($urandom);
      rs = 2'($urandom);
      re = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 24) == 0);
      if (rr) begin
        rz = '0; rzs = 2'b00;
      end else if (re) begin
        case (rs)
          2'd0: rz = ra;
          2'd1: rz = rb;
          2'd2: rz = rc;
          default: rz = rd;
        endcase
        rzs = rs;
      end else begin
        rz = mz; rzs = ms;
      end
      drive(rr, re, rs, ra, rb, rc, rd, rz, rzs);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
